mssd_frame_scheduler: RTL and testbench
=======================================

# mssd_frame_scheduler

Transmit-side controller for the MSSD serial link. Four local requesters each offer a frame: a destination port, a data length and the data bits. The block arbitrates among them round-robin and serialises the winner's frame onto `serOut` in MSSD frame format. It also generates a mid-bit sample strobe that drives the receiver's bit-clock input (`clkPB`-equivalent). It sits between the requesting sources and the MSSD demux, and owns the link exclusively.

## Interface
- `BIT_DIV`, 8: clocks per serial bit; even, ≥4.
- `GAP_BITS`, 2: idle (1) bit-times forced after each frame; ≥1.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req`  in  4  request per source; held high until granted.
- `reqPort`  in  8  2-bit destination port per source (`[2i+1:2i]`).
- `reqLen`  in  16  4-bit data-bit count per source (`[4i+3:4i]`), 0..15.
- `reqData`  in  60  15-bit data per source (`[15i+14:15i]`).
- `gnt`  out  4  one-hot, one-cycle grant pulse.
- `busy`  out  1  high from grant through end of gap.
- `owner`  out  2  index of current/last granted source.
- `serOut`  out  1  serial line; idles high.
- `sampleStb`  out  1  one-cycle pulse at the centre of each transmitted bit.
- `frameDone`  out  1  one-cycle pulse in the last cycle of a frame's last bit.

## Operation
- Frame bit order: start bit (0), then port[1:0] MSB first, then len[3:0] MSB first, then len data bits. Data bits are taken from `data[len-1:0]`, MSB first. Total bits: 7+len.
- States:
  - IDLE: `serOut`=1. If any `req` is high, grant the round-robin winner, latch its port/len/data, and go to START.
  - START → PORT (2 bits) → LEN (4 bits) → DATA (len bits) → GAP (`GAP_BITS` bits) → IDLE.
  - len=0: LEN goes directly to GAP. `frameDone` fires on the last LEN bit.
- Round-robin: search starts at (last owner+1) mod 4. After reset the last owner is 3, so source 0 has top priority. `owner` updates on grant.
- Payload is latched on grant; input changes after grant do not affect the frame in flight.
- A `req` dropped before grant is ignored. Requests arriving during `busy` wait.
- Counters:
  - Prescaler counts 0..BIT_DIV-1 and restarts at 0 on grant.
  - The bit counter reloads at each state entry.
- Reset values: `gnt`=0, `busy`=0, `owner`=3, `serOut`=1, `sampleStb`=0, `frameDone`=0. FSM returns to IDLE.
- Reset mid-frame: `serOut` goes to 1 asynchronously and the frame is abandoned. After reset release, the first grant is no earlier than the first clock edge.

## Timing
- Acceptance edge E. In the cycle after E (call it C0): `gnt[i]`=1 for one cycle, `busy`=1, `serOut`=0 (start bit).
- Every bit is held exactly `BIT_DIV` cycles. Bit k occupies C(k·BIT_DIV) .. C(k·BIT_DIV+BIT_DIV-1).
- `sampleStb` is high at cycle offset `BIT_DIV/2` within every frame bit, including start. It does not pulse during GAP or IDLE.
- `frameDone` is high in the last cycle of the last frame bit.
- GAP holds `serOut`=1 for `GAP_BITS`·`BIT_DIV` cycles. `busy` falls after that. The earliest next `gnt` is in the cycle immediately after `busy` falls, so a back-to-back request costs no extra idle cycles.
- Outputs are registered; there is no combinational path from `req` to `gnt` or `serOut`.

## Structure
- Package `mssd_pkg` holds:
  - state enum (IDLE, START, PORT, LEN, DATA, GAP);
  - constants PORT_W=2, LEN_W=4, DATA_W=15, NREQ=4;
  - line levels IDLE_LVL=1, START_LVL=0.
- Sub-module `rr_arbiter4`: 4-input round-robin arbiter with last-owner pointer, one-hot and index outputs, and an advance-on-grant enable.
- Top level contains the FSM, prescaler, bit counter and payload shift register (PORT+LEN+DATA, loaded on grant).

## Test plan
- Single frame (`BIT_DIV`=4, `GAP_BITS`=2): req0 with port=2, len=3, data=0b101.
  - `serOut` per bit: 0,1,0,0,0,1,1,1,0,1, cycles C0..C39.
  - `sampleStb` at C2, C6, …, C38; `frameDone` at C39.
  - `serOut`=1 for C40..C47; `busy` falls after C47.
- Round-robin: `req`=4'b1111 held continuously.
  - Grants in order 0,1,2,3,0.
  - Each grant follows the previous frame's gap with zero idle cycles.
- len=0 on req2, port=1 → 7 bits 0,0,1,0,0,0,0; `frameDone` on the 7th bit; no DATA bits.
- len=15, data=15'h7FFF on req3 → 22 bits; last 15 bits all 1; 22 `sampleStb` pulses.
- Reset mid-DATA: `rst` low for 3 cycles during bit 9.
  - `serOut`=1 immediately; `busy`=0.
  - After release with `req`=4'b0011, source 0 is granted first.
- Payload change after `gnt`: modify `reqData` the cycle after grant → transmitted bits match the latched value.

Source files
------------

// File: rtl/mssd_pkg.sv
// Shared types and constants for the MSSD transmit-side frame scheduler.
// Holds the FSM state enum, field widths, line levels and the payload packing helper.
package mssd_pkg;

  localparam int unsigned NREQ    = 4;
  localparam int unsigned IDX_W   = 2;
  localparam int unsigned PORT_W  = 2;
  localparam int unsigned LEN_W   = 4;
  localparam int unsigned DATA_W  = 15;
  localparam int unsigned SHIFT_W = PORT_W + LEN_W + DATA_W;

  localparam logic IDLE_LVL  = 1'b1;
  localparam logic START_LVL = 1'b0;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StPort,
    StLen,
    StData,
    StGap
  } state_e;

  // Left-justify the len live data bits so the shifter always emits data[len-1] first.
  function automatic logic [SHIFT_W-1:0] pack_frame(input logic [PORT_W-1:0] port,
                                                    input logic [LEN_W-1:0]  len,
                                                    input logic [DATA_W-1:0] data);
    logic [DATA_W-1:0] aligned;
    aligned = data << (LEN_W'(DATA_W) - len);
    return {port, len, aligned};
  endfunction

endpackage

// File: rtl/mssd_frame_scheduler_if.sv
// Requester/link bundle for the MSSD frame scheduler.
//   master: the requesting sources (drive req/payload, observe grant and line).
//   slave : the scheduler (consumes requests, drives grant, busy, owner and the line).
interface mssd_frame_scheduler_if;
  import mssd_pkg::*;

  logic [NREQ-1:0]        req;
  logic [NREQ*PORT_W-1:0] req_port;
  logic [NREQ*LEN_W-1:0]  req_len;
  logic [NREQ*DATA_W-1:0] req_data;
  logic [NREQ-1:0]        gnt;
  logic                   busy;
  logic [IDX_W-1:0]       owner;
  logic                   ser_out;
  logic                   sample_stb;
  logic                   frame_done;

  modport master (
    output req, req_port, req_len, req_data,
    input  gnt, busy, owner, ser_out, sample_stb, frame_done
  );

  modport slave (
    input  req, req_port, req_len, req_data,
    output gnt, busy, owner, ser_out, sample_stb, frame_done
  );

endinterface

// File: rtl/rr_arbiter4.sv
// Four-input round-robin arbiter.
//   clk_i/rst_ni : clock, async active-low reset (last owner resets to 3)
//   req_i        : request vector
//   en_i         : advance the last-owner pointer to the current winner
//   gnt_o/idx_o  : one-hot winner and its index (combinational)
//   valid_o      : some request is present
//   last_o       : last granted index
module rr_arbiter4
  import mssd_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [NREQ-1:0]  req_i,
  input  logic             en_i,
  output logic [NREQ-1:0]  gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o,
  output logic [IDX_W-1:0] last_o
);

  logic [IDX_W-1:0] last_q, last_d;

  // Search starts one past the last owner; the last owner itself is checked last.
  always_comb begin
    logic [IDX_W-1:0] cand;
    cand    = '0;
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = last_q + IDX_W'(k);
      if (!valid_o && req_i[cand]) begin
        valid_o     = 1'b1;
        idx_o       = cand;
        gnt_o[cand] = 1'b1;
      end
    end
  end

  always_comb begin
    last_d = last_q;
    if (en_i && valid_o) last_d = idx_o;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) last_q <= IDX_W'(NREQ - 1);
    else         last_q <= last_d;
  end

  assign last_o = last_q;

endmodule

// File: rtl/mssd_frame_scheduler.sv
// MSSD transmit frame scheduler: arbitrates four requesters round-robin and serialises the
// winner's frame (start, port, len, data) onto ser_out, followed by an idle gap.
//   clk_i/rst_ni : clock, async active-low reset (line forced idle, frame abandoned)
//   bus          : slave side of mssd_frame_scheduler_if (requests in; gnt, busy, owner,
//                  ser_out, sample_stb, frame_done out)
module mssd_frame_scheduler
  import mssd_pkg::*;
#(
  parameter int unsigned BIT_DIV  = 8,
  parameter int unsigned GAP_BITS = 2
) (
  input logic                   clk_i,
  input logic                   rst_ni,
  mssd_frame_scheduler_if.slave bus
);

  localparam int unsigned PreW = $clog2(BIT_DIV);
  localparam int unsigned CntW = ($clog2(GAP_BITS) > LEN_W) ? $clog2(GAP_BITS) : LEN_W;
  localparam logic [PreW-1:0] PreLast = PreW'(BIT_DIV - 1);
  localparam logic [PreW-1:0] PreMid  = PreW'(BIT_DIV / 2);
  localparam logic [CntW-1:0] GapLoad = CntW'(GAP_BITS - 1);

  state_e               state_q, state_d;
  logic [PreW-1:0]      pre_q, pre_d;
  logic [CntW-1:0]      bit_q, bit_d;
  logic [SHIFT_W-1:0]   shift_q, shift_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [NREQ-1:0]      gnt_q, gnt_d;

  logic [NREQ-1:0]      arb_gnt;
  logic [IDX_W-1:0]     arb_idx;
  logic [IDX_W-1:0]     arb_last;
  logic                 arb_valid;
  logic                 grant_now;
  logic                 bit_end;
  logic                 last_bit;
  logic [PORT_W-1:0]    sel_port;
  logic [LEN_W-1:0]     sel_len;
  logic [DATA_W-1:0]    sel_data;

  rr_arbiter4 u_arb (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .req_i   (bus.req),
    .en_i    (grant_now),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid),
    .last_o  (arb_last)
  );

  assign bit_end  = (pre_q == PreLast);
  assign last_bit = bit_end && (bit_q == '0);
  // A frame may start straight out of the last gap cycle, so back-to-back requests see no idle.
  assign grant_now = arb_valid && ((state_q == StIdle) || ((state_q == StGap) && last_bit));

  always_comb begin
    sel_port = '0;
    sel_len  = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_gnt[i]) begin
        sel_port = bus.req_port[i*PORT_W +: PORT_W];
        sel_len  = bus.req_len[i*LEN_W +: LEN_W];
        sel_data = bus.req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next-state: bit_q holds bits remaining minus one in the current state.
  always_comb begin
    state_d = state_q;
    pre_d   = bit_end ? '0 : pre_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    len_d   = len_q;
    gnt_d   = '0;
    unique case (state_q)
      StIdle: pre_d = '0;
      StStart: begin
        if (bit_end) begin
          state_d = StPort;
          bit_d   = CntW'(PORT_W - 1);
        end
      end
      StPort: begin
        if (bit_end) begin
          shift_d = shift_q << 1;
          if (bit_q == '0) begin
            state_d = StLen;
            bit_d   = CntW'(LEN_W - 1);
          end else begin
            bit_d = bit_q - 1'b1;
          end
        end
      end
      StLen: begin
        if (bit_end) begin
          shift_d = shift_q << 1;
          if (bit_q != '0) begin
            bit_d = bit_q - 1'b1;
          end else if (len_q == '0) begin
            state_d = StGap;
            bit_d   = GapLoad;
          end else begin
            state_d = StData;
            bit_d   = CntW'(len_q) - 1'b1;
          end
        end
      end
      StData: begin
        if (bit_end) begin
          shift_d = shift_q << 1;
          if (bit_q == '0) begin
            state_d = StGap;
            bit_d   = GapLoad;
          end else begin
            bit_d = bit_q - 1'b1;
          end
        end
      end
      StGap: begin
        if (bit_end) begin
          if (bit_q == '0) state_d = StIdle;
          else             bit_d   = bit_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (grant_now) begin
      state_d = StStart;
      pre_d   = '0;
      bit_d   = '0;
      shift_d = pack_frame(sel_port, sel_len, sel_data);
      len_d   = sel_len;
      gnt_d   = arb_gnt;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      pre_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      len_q   <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      len_q   <= len_d;
      gnt_q   <= gnt_d;
    end
  end

  // Outputs decode registered state only; reset drives the line idle asynchronously.
  always_comb begin
    bus.gnt        = gnt_q;
    bus.busy       = (state_q != StIdle);
    bus.owner      = arb_last;
    bus.ser_out    = IDLE_LVL;
    bus.sample_stb = 1'b0;
    bus.frame_done = 1'b0;
    unique case (state_q)
      StIdle, StGap: bus.ser_out = IDLE_LVL;
      StStart: begin
        bus.ser_out    = START_LVL;
        bus.sample_stb = (pre_q == PreMid);
      end
      StPort: begin
        bus.ser_out    = shift_q[SHIFT_W-1];
        bus.sample_stb = (pre_q == PreMid);
      end
      StLen: begin
        bus.ser_out    = shift_q[SHIFT_W-1];
        bus.sample_stb = (pre_q == PreMid);
        bus.frame_done = last_bit && (len_q == '0);
      end
      StData: begin
        bus.ser_out    = shift_q[SHIFT_W-1];
        bus.sample_stb = (pre_q == PreMid);
        bus.frame_done = last_bit;
      end
      default: bus.ser_out = IDLE_LVL;
    endcase
  end

endmodule

// File: tb/tb_mssd_frame_scheduler.sv
// Directed bench for mssd_frame_scheduler with BIT_DIV=4, GAP_BITS=2.
module tb_mssd_frame_scheduler;
  import mssd_pkg::*;

  localparam int BD = 4;
  localparam int GB = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  mssd_frame_scheduler_if bus ();

  mssd_frame_scheduler #(
    .BIT_DIV  (BD),
    .GAP_BITS (GB)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int s, input logic [1:0] p, input logic [3:0] l,
                         input logic [14:0] d);
    bus.req_port[s*2 +: 2]   = p;
    bus.req_len[s*4 +: 4]    = l;
    bus.req_data[s*15 +: 15] = d;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
  endtask

  // Leaves the bench in cycle C0 of the granted frame.
  task automatic wait_gnt();
    int n;
    n = 0;
    while (bus.gnt == '0 && n < 20) begin
      tick();
      n++;
    end
    check_eq("gnt_seen", 32'(|bus.gnt), 32'd1);
  endtask

  // Checks every cycle of a frame plus its gap, starting at C0.
  task automatic check_frame(input int src, input logic [1:0] port, input logic [3:0] len,
                             input logic [14:0] data, input logic [3:0] req_after,
                             input bit scramble, output logic [21:0] cap, output int nstb);
    logic frame [22];
    int   nb;
    int   total;
    logic exp_ser;
    nb = 7 + int'(len);
    frame[0] = 1'b0;
    frame[1] = port[1];
    frame[2] = port[0];
    for (int j = 0; j < 4; j++) frame[3+j] = len[3-j];
    for (int j = 7; j < 22; j++) frame[j] = 1'b0;
    for (int j = 0; j < int'(len); j++) frame[7+j] = data[int'(len)-1-j];
    total = (nb + GB) * BD;
    cap   = '0;
    nstb  = 0;
    for (int c = 0; c < total; c++) begin
      exp_ser = (c < nb * BD) ? frame[c / BD] : 1'b1;
      check_eq($sformatf("ser s%0d c%0d", src, c), 32'(bus.ser_out), 32'(exp_ser));
      check_eq($sformatf("stb s%0d c%0d", src, c), 32'(bus.sample_stb),
               32'((c < nb * BD) && (c % BD == BD / 2)));
      check_eq($sformatf("done s%0d c%0d", src, c), 32'(bus.frame_done),
               32'(c == nb * BD - 1));
      check_eq($sformatf("busy s%0d c%0d", src, c), 32'(bus.busy), 32'd1);
      check_eq($sformatf("gnt s%0d c%0d", src, c), 32'(bus.gnt),
               (c == 0) ? (32'd1 << src) : 32'd0);
      if (c == 0) check_eq($sformatf("owner s%0d", src), 32'(bus.owner), 32'(src));
      if (bus.sample_stb) begin
        cap = {cap[20:0], bus.ser_out};
        nstb++;
      end
      if (c == 0) begin
        bus.req = req_after;
        if (scramble) set_src(src, ~port, ~len, ~data);
      end
      tick();
    end
  endtask

  logic [14:0] rr_data [4];
  int          rr_order [5];
  logic [21:0] cap;
  int          nstb;

  initial begin
    rr_data  = '{15'h2AAA, 15'h1357, 15'h7001, 15'h0F0F};
    rr_order = '{0, 1, 2, 3, 0};
    bus.req      = '0;
    bus.req_port = '0;
    bus.req_len  = '0;
    bus.req_data = '0;

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_gnt", 32'(bus.gnt), 32'd0);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_owner", 32'(bus.owner), 32'd3);
    check_eq("rst_ser", 32'(bus.ser_out), 32'd1);
    check_eq("rst_stb", 32'(bus.sample_stb), 32'd0);
    check_eq("rst_done", 32'(bus.frame_done), 32'd0);
    repeat (3) tick();
    rst_n = 1'b1;

    // Single frame: port 2, len 3, data 101
    set_src(0, 2'd2, 4'd3, 15'h0005);
    bus.req = 4'b0001;
    wait_gnt();
    check_frame(0, 2'd2, 4'd3, 15'h0005, 4'b0000, 1'b0, cap, nstb);
    check_eq("t1_bits", 32'(cap[9:0]), 32'h11D);
    check_eq("t1_nstb", 32'(nstb), 32'd10);
    check_eq("t1_busy_after", 32'(bus.busy), 32'd0);

    // Round-robin with all four requests held
    do_reset();
    for (int s = 0; s < 4; s++) set_src(s, 2'(3 - s), 4'(s + 1), rr_data[s]);
    bus.req = 4'b1111;
    wait_gnt();
    for (int k = 0; k < 5; k++) begin
      check_frame(rr_order[k], 2'(3 - rr_order[k]), 4'(rr_order[k] + 1),
                  rr_data[rr_order[k]], (k == 4) ? 4'b0000 : 4'b1111, 1'b0, cap, nstb);
    end
    check_eq("rr_busy_after", 32'(bus.busy), 32'd0);

    // len=0 on source 2
    set_src(2, 2'd1, 4'd0, 15'h7FFF);
    bus.req = 4'b0100;
    wait_gnt();
    check_frame(2, 2'd1, 4'd0, 15'h7FFF, 4'b0000, 1'b0, cap, nstb);
    check_eq("t3_bits", 32'(cap[6:0]), 32'h10);
    check_eq("t3_nstb", 32'(nstb), 32'd7);

    // len=15, all-ones data on source 3
    set_src(3, 2'd0, 4'd15, 15'h7FFF);
    bus.req = 4'b1000;
    wait_gnt();
    check_frame(3, 2'd0, 4'd15, 15'h7FFF, 4'b0000, 1'b0, cap, nstb);
    check_eq("t4_bits", 32'(cap), 32'h07FFFF);
    check_eq("t4_nstb", 32'(nstb), 32'd22);

    // Reset during DATA bit 9
    set_src(0, 2'd1, 4'd8, 15'h0085);
    set_src(1, 2'd2, 4'd5, 15'h0013);
    bus.req = 4'b0001;
    wait_gnt();
    check_eq("t5_gnt", 32'(bus.gnt), 32'h1);
    bus.req = 4'b0011;
    repeat (37) tick();
    check_eq("t5_pre_rst_ser", 32'(bus.ser_out), 32'd0);
    rst_n = 1'b0;
    #1;
    check_eq("t5_rst_ser", 32'(bus.ser_out), 32'd1);
    check_eq("t5_rst_busy", 32'(bus.busy), 32'd0);
    check_eq("t5_rst_gnt", 32'(bus.gnt), 32'd0);
    check_eq("t5_rst_owner", 32'(bus.owner), 32'd3);
    repeat (3) tick();
    rst_n = 1'b1;
    wait_gnt();
    check_frame(0, 2'd1, 4'd8, 15'h0085, 4'b0010, 1'b0, cap, nstb);

    // Payload of source 1 inverted in C0; the latched frame must go out unchanged
    check_frame(1, 2'd2, 4'd5, 15'h0013, 4'b0000, 1'b1, cap, nstb);
    check_eq("t6_bits", 32'(cap[11:0]), 32'h4B3);
    check_eq("t6_nstb", 32'(nstb), 32'd12);
    check_eq("t6_busy_after", 32'(bus.busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
